// File: rtl/kp_scan_controller.sv
// 4x4 matrix keypad scanner: column drive, row sampling, press/release debounce,
// and a single-cycle shift strobe carrying the encoded key per accepted press.
module kp_scan_controller #(
  parameter int SCAN_DIV   = 16,
  parameter int DEBOUNCE_N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       shift,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_N + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} state_t;

  state_t          state, state_nx;
  logic [DW-1:0]   div;
  logic            tick;
  logic [1:0]      col_idx, col_nx;
  logic [1:0]      row_idx, row_nx;
  logic [CW-1:0]   dcnt, dcnt_nx;
  logic [3:0]      code_nx;
  logic [1:0]      low_idx;
  logic            any_low;

  assign tick    = (div == DW'(SCAN_DIV - 1));
  assign any_low = ~&row_n;
  assign col_n   = ~(4'b0001 << col_idx);
  assign shift   = (state == EMIT);
  assign key_held = (state == EMIT) || (state == RELEASE);

  // Lowest-index low row wins when several rows are pressed together.
  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!row_n[i]) low_idx = 2'(i);
  end

  always_comb begin
    state_nx = state;
    col_nx   = col_idx;
    row_nx   = row_idx;
    dcnt_nx  = dcnt;
    code_nx  = key_code;
    case (state)
      SCAN: if (tick) begin
        if (any_low) begin
          row_nx   = low_idx;
          dcnt_nx  = CW'(1);
          state_nx = DEBOUNCE;
        end else begin
          col_nx = col_idx + 2'd1;
        end
      end
      DEBOUNCE: if (tick) begin
        if (!row_n[row_idx]) begin
          dcnt_nx = dcnt + CW'(1);
          // Load the code on entry so it is already valid while shift is high.
          if (dcnt_nx == CW'(DEBOUNCE_N)) begin
            state_nx = EMIT;
            code_nx  = ~{row_idx, col_idx};
          end
        end else begin
          state_nx = SCAN;
          col_nx   = col_idx + 2'd1;
        end
      end
      EMIT: begin
        dcnt_nx  = '0;
        state_nx = RELEASE;
      end
      RELEASE: if (tick) begin
        if (&row_n) begin
          dcnt_nx = dcnt + CW'(1);
          if (dcnt_nx == CW'(DEBOUNCE_N)) begin
            state_nx = SCAN;
            col_nx   = col_idx + 2'd1;
          end
        end else begin
          dcnt_nx = '0;
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SCAN;
      div      <= '0;
      col_idx  <= 2'd0;
      row_idx  <= 2'd0;
      dcnt     <= '0;
      key_code <= 4'd0;
    end else begin
      state    <= state_nx;
      div      <= tick ? '0 : div + DW'(1);
      col_idx  <= col_nx;
      row_idx  <= row_nx;
      dcnt     <= dcnt_nx;
      key_code <= code_nx;
    end
  end

endmodule

// File: tb/tb_kp_scan_controller.sv
// Randomized bench for kp_scan_controller; expectations come from tick/column
// arithmetic over cycle numbers plus a simple keypad switch model.
module tb_kp_scan_controller;
  localparam int SD = 4;
  localparam int DN = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_n, col_n, key_code;
  logic        shift, key_held;
  logic [15:0] keys = '0;

  int          checks = 0;
  int          failures = 0;
  int          cyc, base, cb;
  logic [3:0]  cur_code;

  always #5 clk = ~clk;

  kp_scan_controller #(.SCAN_DIV(SD), .DEBOUNCE_N(DN)) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
    .key_code(key_code), .shift(shift), .key_held(key_held)
  );

  // Switch matrix: a closed key pulls its row low while its column is driven.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  // Idle column in cycle k: one column per SD cycles starting from cb at base.
  function automatic int col_at(int k);
    return (cb + (k - base) / SD) % 4;
  endfunction

  function automatic int next_match(int from, int c);
    int k = from;
    while (!((k % SD == SD - 1) && (col_at(k) == c))) k++;
    return k;
  endfunction

  function automatic logic [15:0] key_mask(logic [3:0] rows, int c);
    logic [15:0] m = '0;
    for (int r = 0; r < 4; r++) if (rows[r]) m[r*4+c] = 1'b1;
    return m;
  endfunction

  task automatic step();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    keys = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0; base = 0; cb = 0; cur_code = 4'd0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (col_n !== 4'b1110) begin failures++; $display("FAIL reset_col got=%b want=1110", col_n); end
    checks++; if (shift !== 1'b0) begin failures++; $display("FAIL reset_shift got=%b want=0", shift); end
    checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL reset_code got=%b want=0000", key_code); end
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL reset_held got=%b want=0", key_held); end
  endtask

  task automatic test_idle();
    logic [3:0] ec;
    keys = '0;
    repeat (24) begin
      ec = ~(4'b0001 << col_at(cyc));
      checks++; if (col_n !== ec) begin failures++; $display("FAIL idle_col cyc=%0d got=%b want=%b", cyc, col_n, ec); end
      checks++; if (shift !== 1'b0) begin failures++; $display("FAIL idle_shift cyc=%0d got=%b want=0", cyc, shift); end
      step();
    end
  endtask

  // Press the keys in `rows` of column c after d cycles; either hold for `hold`
  // cycles past the strobe, or (bounce) let go after DN-1 accepted ticks.
  task automatic test_key_sequence(logic [3:0] rows, int c, int d, int hold, bit bounce);
    int p, t, s, rel, e, stop, r;
    logic [1:0] rr, cc, ecol;
    logic [3:0] newc, ecode, ecn;
    logic [15:0] m;
    bit es, eh;
    p = cyc + d;
    t = next_match(p, c);
    r = 0;
    for (int i = 3; i >= 0; i--) if (rows[i]) r = i;
    rr = 2'(r); cc = 2'(c);
    newc = ~{rr, cc};
    m = key_mask(rows, c);
    if (bounce) begin
      s = -1;
      rel = t + (DN - 2) * SD + 1;
      e = t + (DN - 1) * SD;
    end else begin
      s = t + (DN - 1) * SD + 1;
      rel = s + hold;
      e = rel;
      while (e % SD != SD - 1) e++;
      e = e + (DN - 1) * SD;
    end
    stop = e + SD;
    while (cyc <= stop) begin
      keys = (cyc >= p && cyc < rel) ? m : '0;
      if (cyc <= t) ecol = 2'(col_at(cyc));
      else if (cyc <= e) ecol = cc;
      else ecol = cc + 2'd1;
      ecn = ~(4'b0001 << ecol);
      es = (cyc == s);
      eh = !bounce && cyc >= s && cyc <= e;
      ecode = (!bounce && cyc >= s) ? newc : cur_code;
      checks++; if (col_n !== ecn) begin failures++; $display("FAIL seq_col cyc=%0d got=%b want=%b", cyc, col_n, ecn); end
      checks++; if (shift !== es) begin failures++; $display("FAIL seq_shift cyc=%0d got=%b want=%b", cyc, shift, es); end
      checks++; if (key_held !== eh) begin failures++; $display("FAIL seq_held cyc=%0d got=%b want=%b", cyc, key_held, eh); end
      checks++; if (key_code !== ecode) begin failures++; $display("FAIL seq_code cyc=%0d got=%b want=%b", cyc, key_code, ecode); end
      step();
    end
    keys = '0;
    base = e + 1;
    cb = (c + 1) % 4;
    if (!bounce) cur_code = newc;
  endtask

  task automatic test_press();
    do_reset();
    // The documented example: row1 while column 2 is driven -> 1001.
    test_key_sequence(4'b0010, 2, 0, 20, 1'b0);
    repeat (6) begin
      logic [3:0] rows;
      rows = 4'b0001 << $urandom_range(0, 3);
      test_key_sequence(rows, $urandom_range(0, 3), $urandom_range(0, 40), $urandom_range(1, 60), 1'b0);
    end
  endtask

  task automatic test_two_rows();
    repeat (3) begin
      logic [3:0] rows;
      do rows = 4'($urandom_range(3, 15)); while ($countones(rows) < 2);
      test_key_sequence(rows, $urandom_range(0, 3), $urandom_range(0, 20), $urandom_range(1, 30), 1'b0);
    end
  endtask

  task automatic test_bounce();
    repeat (3) begin
      logic [3:0] rows;
      rows = 4'b0001 << $urandom_range(0, 3);
      test_key_sequence(rows, $urandom_range(0, 3), $urandom_range(0, 20), 0, 1'b1);
    end
  endtask

  task automatic test_clear_hold();
    test_key_sequence(4'b1000, 3, 3, 1000, 1'b0);
    test_key_sequence(4'b1000, 3, 10, 8, 1'b0);
  endtask

  task automatic test_rst_mid_debounce();
    repeat (2) begin
      int c, p, t;
      logic [15:0] m;
      do_reset();
      c = $urandom_range(0, 3);
      p = cyc + $urandom_range(0, 10);
      t = next_match(p, c);
      m = key_mask(4'b0001 << $urandom_range(0, 3), c);
      while (cyc <= t + SD + 1) begin
        keys = (cyc >= p) ? m : '0;
        checks++; if (shift !== 1'b0) begin failures++; $display("FAIL rstdb_shift cyc=%0d got=%b want=0", cyc, shift); end
        if (cyc == t + SD + 1) rst = 1'b1;
        step();
      end
      keys = '0;
      checks++; if (col_n !== 4'b1110) begin failures++; $display("FAIL rstdb_col got=%b want=1110", col_n); end
      checks++; if (shift !== 1'b0) begin failures++; $display("FAIL rstdb_shift_after got=%b want=0", shift); end
      checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL rstdb_held got=%b want=0", key_held); end
      checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL rstdb_code got=%b want=0000", key_code); end
      rst = 1'b0;
      cyc = 0; base = 0; cb = 0; cur_code = 4'd0;
      test_idle();
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_press();
    test_two_rows();
    test_bounce();
    test_clear_hold();
    test_rst_mid_debounce();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
